// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between fetch (port 0) and load/store (port 1).
// Optional feature macro ARB_TIMEOUT_EN: abort a transaction left BUSY for TIMEOUT cycles without mem_done.

module mux32_2_1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] y
);
    assign y = s ? b : a;
endmodule

module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        we0,
    output logic        gnt0,
    output logic        done0,
    output logic        err0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    output logic        gnt1,
    output logic        done1,
    output logic        err1,
    output logic        mem_sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       last, last_nxt, sel_nxt;
    logic       busy, abort, fin;
    logic [1:0] req, gnt, done, err;

    assign req  = {req1, req0};
    assign busy = (state == BUSY);

    mux32_2_1 u_addr_mux  (.a(addr0),  .b(addr1),  .s(mem_sel), .y(mem_addr));
    mux32_2_1 u_wdata_mux (.a(wdata0), .b(wdata1), .s(mem_sel), .y(mem_wdata));

`ifdef ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;

    // Held at zero while idle, so every transaction starts counting from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (!busy)
            to_cnt <= '0;
        else if (!mem_done)
            to_cnt <= to_cnt + 1'b1;
    end

    assign abort = busy && !mem_done && (to_cnt == TO_LAST);
`else
    logic [TO_W-1:0] unused_to;
    assign unused_to = TO_W'(TIMEOUT);
    assign abort     = 1'b0;
`endif

    assign fin = busy && (mem_done || abort);

    always_comb begin
        state_nxt = state;
        sel_nxt   = mem_sel;
        last_nxt  = last;
        if (state == IDLE) begin
            if (|req) begin
                state_nxt = BUSY;
                // On a tie the port that did not win last time goes first.
                sel_nxt   = (&req) ? ~last : req[1];
            end
        end else if (fin) begin
            state_nxt = IDLE;
            last_nxt  = mem_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            mem_sel <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            mem_sel <= sel_nxt;
        end
    end

    assign gnt  = busy ? (mem_sel ? 2'b10 : 2'b01) : 2'b00;
    assign done = (busy && mem_done) ? gnt : 2'b00;
    assign err  = abort ? gnt : 2'b00;

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign done0   = done[0];
    assign done1   = done[1];
    assign err0    = err[0];
    assign err1    = err[1];
    assign mem_req = busy;
    assign mem_we  = busy && (mem_sel ? we1 : we0);
    assign rdata   = mem_rdata;
endmodule
